// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver that deserialises 16-bit stereo frames in the clk_i domain.
// Optional mono mix output enabled by defining I2S_RX_MONO_EN.
module i2s_rx #(
  parameter int SLOT_BITS = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        sck_i,
  input  logic        ws_i,
  input  logic        sd_i,
  output logic [15:0] left_o,
  output logic [15:0] right_o,
`ifdef I2S_RX_MONO_EN
  output logic [15:0] mono_o,
`endif
  output logic        valid_o,
  output logic        err_o
);
  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] CMAX = CW'(SLOT_BITS + 1);
  localparam logic [CW-1:0] CLIM = CW'(SLOT_BITS);
  localparam logic [CW-1:0] C16 = CW'(16);
  typedef enum logic {ALIGN, RECV} state_t;
  state_t state;
  logic [1:0] sck_m, ws_m, sd_m;
  logic sck_d, ws_prev, ch, pair_ok;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] sr, word, left_hold;
  logic rise, ws_chg, done, err;
  always_comb begin
    rise = sck_m[1] & ~sck_d;
    ws_chg = ws_m[1] ^ ws_prev;
    cnt_n = (cnt == CMAX) ? cnt : cnt + CW'(1);
    word = (cnt < C16) ? {sr[14:0], sd_m[1]} : sr;
    done = cnt_n == C16;
    // short slot closed by a ws change, or slot overrun (fires once: count saturates)
    err = (ws_chg && cnt_n < C16) || (cnt_n > CLIM && cnt <= CLIM);
  end
`ifdef I2S_RX_MONO_EN
  logic signed [16:0] sum;
  always_comb sum = $signed({left_hold[15], left_hold}) + $signed({word[15], word});
`endif
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_m <= '0;
      ws_m <= '0;
      sd_m <= '0;
      sck_d <= 1'b0;
      ws_prev <= 1'b0;
      state <= ALIGN;
      cnt <= '0;
      ch <= 1'b0;
      pair_ok <= 1'b0;
      sr <= '0;
      left_hold <= '0;
      left_o <= '0;
      right_o <= '0;
`ifdef I2S_RX_MONO_EN
      mono_o <= '0;
`endif
      valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      sck_m <= {sck_m[0], sck_i};
      ws_m <= {ws_m[0], ws_i};
      sd_m <= {sd_m[0], sd_i};
      sck_d <= sck_m[1];
      valid_o <= 1'b0;
      err_o <= 1'b0;
      if (rise) begin
        ws_prev <= ws_m[1];
        if (state == ALIGN) begin
          // the 1->0 edge still carries the previous slot's LSB; left MSB follows
          if (ws_prev && !ws_m[1]) begin
            state <= RECV;
            cnt <= '0;
            ch <= 1'b0;
            pair_ok <= 1'b1;
          end
        end else begin
          if (cnt < C16) sr <= word;
          cnt <= ws_chg ? '0 : cnt_n;
          if (done && !ch) left_hold <= word;
          if (done && ch && pair_ok) begin
            left_o <= left_hold;
            right_o <= word;
`ifdef I2S_RX_MONO_EN
            mono_o <= 16'(sum >>> 1);
`endif
            valid_o <= 1'b1;
          end
          if (err) begin
            err_o <= 1'b1;
            pair_ok <= 1'b0;
          end
          if (ws_chg) begin
            ch <= ws_m[1];
            if (!ws_m[1]) pair_ok <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx driving directed I2S frames.
module tb_i2s_rx;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic sck_i = 1'b0;
  logic ws_i = 1'b1;
  logic sd_i = 1'b0;
  logic [15:0] left_o, right_o;
`ifdef I2S_RX_MONO_EN
  logic [15:0] mono_o;
`endif
  logic valid_o, err_o;
  int checks = 0;
  int errors = 0;
  logic prev_d = 1'b0;
  typedef struct {
    bit is_err;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] m;
  } exp_t;
  exp_t sb[$];

  i2s_rx #(.SLOT_BITS(32)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .sck_i(sck_i),
    .ws_i(ws_i),
    .sd_i(sd_i),
    .left_o(left_o),
    .right_o(right_o),
`ifdef I2S_RX_MONO_EN
    .mono_o(mono_o),
`endif
    .valid_o(valid_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit e, input logic [15:0] l, input logic [15:0] r, input logic [15:0] m);
    exp_t x;
    x.is_err = e;
    x.l = l;
    x.r = r;
    x.m = m;
    sb.push_back(x);
  endtask

  // one bit clock; sd lags ws by one bit as on a real I2S bus
  task automatic emit(input logic w, input logic d);
    ws_i = w;
    sd_i = prev_d;
    prev_d = d;
    #40 sck_i = 1'b1;
    #40 sck_i = 1'b0;
  endtask

  task automatic slot(input logic w, input logic [15:0] word, input int n);
    for (int k = 0; k < n; k++) emit(w, k < 16 ? word[15-k] : 1'b0);
  endtask

  always @(negedge clk) begin
    if (!reset_i && (valid_o || err_o)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: valid=%0b err=%0b expected none at %0t", valid_o, err_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind", {14'd0, valid_o, err_o}, e.is_err ? 16'd1 : 16'd2);
        if (!e.is_err) begin
          chk("left", left_o, e.l);
          chk("right", right_o, e.r);
`ifdef I2S_RX_MONO_EN
          chk("mono", mono_o, e.m);
`endif
        end
      end
    end
  end

  initial begin
    #22;
    chk("rst_left", left_o, 16'h0);
    chk("rst_right", right_o, 16'h0);
    chk("rst_flags", {14'd0, valid_o, err_o}, 16'h0);
`ifdef I2S_RX_MONO_EN
    chk("rst_mono", mono_o, 16'h0);
`endif
    reset_i = 1'b0;
    for (int i = 0; i < 40; i++) emit(1'b1, 1'($urandom_range(0, 1)));
    chk("align_left", left_o, 16'h0);
    chk("align_right", right_o, 16'h0);
    push(1'b0, 16'h1234, 16'h8001, 16'hC91A);
    slot(1'b0, 16'h1234, 32);
    slot(1'b1, 16'h8001, 32);
    push(1'b0, 16'h1234, 16'h8001, 16'hC91A);
    slot(1'b0, 16'h1234, 32);
    slot(1'b1, 16'h8001, 32);
    push(1'b0, 16'h7FFF, 16'h8000, 16'hFFFF);
    slot(1'b0, 16'h7FFF, 16);
    slot(1'b1, 16'h8000, 16);
    push(1'b1, 16'h0, 16'h0, 16'h0);
    slot(1'b0, 16'h5555, 10);
    slot(1'b1, 16'hAAAA, 32);
    push(1'b0, 16'h0001, 16'h0002, 16'h0001);
    slot(1'b0, 16'h0001, 32);
    slot(1'b1, 16'h0002, 32);
    push(1'b1, 16'h0, 16'h0, 16'h0);
    slot(1'b0, 16'h1111, 40);
    slot(1'b1, 16'h2222, 32);
    slot(1'b0, 16'h3333, 32);
    slot(1'b1, 16'h4444, 8);
    #3 reset_i = 1'b1;
    #2;
    chk("midrst_left", left_o, 16'h0);
    chk("midrst_right", right_o, 16'h0);
    chk("midrst_flags", {14'd0, valid_o, err_o}, 16'h0);
    #10 reset_i = 1'b0;
    for (int i = 0; i < 24; i++) emit(1'b1, 1'b1);
    push(1'b0, 16'h0100, 16'hFF00, 16'h0000);
    slot(1'b0, 16'h0100, 32);
    slot(1'b1, 16'hFF00, 32);
    slot(1'b0, 16'h0000, 4);
    repeat (20) @(posedge clk);
    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
